// File: rtl/alu.sv
// alu: registered WIDTH-bit ALU with 3-bit op select and {CF,ZF,OF,SF} flags
module alu #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       f
);
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] r;
  logic             cf, of, ov_add, ov_sub, lt;
  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign ov_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign ov_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  // signed less-than must correct the difference sign for overflow
  assign lt     = diff[WIDTH-1] ^ ov_sub;
  always_comb begin
    r  = '0;
    cf = 1'b0;
    of = 1'b0;
    case (s)
      3'b000: begin
        r  = sum[WIDTH-1:0];
        cf = sum[WIDTH];
        of = ov_add;
      end
      3'b001: begin
        r  = diff[WIDTH-1:0];
        cf = diff[WIDTH];
        of = ov_sub;
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = ~a;
      3'b101: r = a ^ b;
      3'b110: r = ~(a | b);
      default: r = {{(WIDTH-1){1'b0}}, lt};
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y <= '0;
      f <= 4'b0000;
    end else begin
      y <= r;
      f <= {cf, r == '0, of, r[WIDTH-1]};
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and randomized checks of alu against an integer-arithmetic model
module tb_alu;
  localparam int W = 6;
  localparam int M = 1 << W;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   s = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] y;
  logic [3:0]   f;
  int passed = 0, total = 0;

  alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .s(s), .a(a), .b(b), .y(y), .f(f));

  always #5 clk = ~clk;

  function automatic int sgn(input int u);
    return (u >= M/2) ? u - M : u;
  endfunction

  function automatic void model(input int op, input int ua, input int ub, output int ey, output int ef);
    int sa, sb, full, cf, of;
    sa = sgn(ua);
    sb = sgn(ub);
    cf = 0;
    of = 0;
    case (op)
      0: begin full = ua + ub; cf = int'(full >= M); of = int'(sa + sb > M/2-1 || sa + sb < -M/2); end
      1: begin full = ua - ub; cf = int'(ua < ub);   of = int'(sa - sb > M/2-1 || sa - sb < -M/2); end
      2: full = ua & ub;
      3: full = ua | ub;
      4: full = M - 1 - ua;
      5: full = ua ^ ub;
      6: full = M - 1 - (ua | ub);
      default: full = int'(sa < sb);
    endcase
    ey = ((full % M) + M) % M;
    ef = cf * 8 + int'(ey == 0) * 4 + of * 2 + int'(ey >= M/2);
  endfunction

  task automatic check(input string tag, input int ey, input int ef);
    total++;
    assert (y === W'(ey)) passed++;
    else $error("FAIL %s y: got %b expected %b", tag, y, W'(ey));
    total++;
    assert (f === 4'(ef)) passed++;
    else $error("FAIL %s f: got %b expected %b", tag, f, 4'(ef));
  endtask

  task automatic step(input string tag, input logic r, input int op, input int ua, input int ub);
    int ey, ef;
    rst_n = r;
    s = 3'(op);
    a = W'(ua);
    b = W'(ub);
    @(posedge clk);
    #1;
    if (r) model(op, ua, ub, ey, ef);
    else begin ey = 0; ef = 0; end
    check(tag, ey, ef);
  endtask

  task automatic spec(input string tag, input int op, input int ua, input int ub, input int ey, input int ef);
    rst_n = 1'b1;
    s = 3'(op);
    a = W'(ua);
    b = W'(ub);
    @(posedge clk);
    #1;
    check(tag, ey, ef);
  endtask

  initial begin
    step("reset", 1'b0, 3, 6'b101010, 6'b010101);
    spec("add_0_m32", 0, 6'b000000, 6'b100000, 6'b100000, 4'b0001);
    spec("sub_0_m32", 1, 6'b000000, 6'b100000, 6'b100000, 4'b1011);
    spec("add_v3", 0, 6'b001100, 6'b101111, 6'b111011, 4'b0001);
    spec("sub_v3", 1, 6'b001100, 6'b101111, 6'b011101, 4'b1000);
    spec("add_v4", 0, 6'b101001, 6'b001100, 6'b110101, 4'b0001);
    spec("sub_v4", 1, 6'b101001, 6'b001100, 6'b011101, 4'b0010);
    spec("add_v5", 0, 6'b101100, 6'b110100, 6'b100000, 4'b1001);
    spec("sub_v5", 1, 6'b101100, 6'b110100, 6'b111000, 4'b1001);
    spec("and_v5", 2, 6'b101100, 6'b110100, 6'b100100, 4'b0001);
    spec("or_v5",  3, 6'b101100, 6'b110100, 6'b111100, 4'b0001);
    spec("not_v5", 4, 6'b101100, 6'b110100, 6'b010011, 4'b0000);
    spec("xor_v5", 5, 6'b101100, 6'b110100, 6'b011000, 4'b0000);
    spec("nor_v5", 6, 6'b101100, 6'b110100, 6'b000011, 4'b0000);
    spec("slt_v5", 7, 6'b101100, 6'b110100, 6'b000001, 4'b0000);
    spec("add_wrap", 0, 6'b111111, 6'b000001, 6'b000000, 4'b1100);
    spec("sub_eq", 1, 6'b010101, 6'b010101, 6'b000000, 4'b0100);
    spec("slt_ovf", 7, 6'b100000, 6'b011111, 6'b000001, 4'b0000);
    spec("slt_ovf2", 7, 6'b011111, 6'b100000, 6'b000000, 4'b0100);
    step("mid_reset", 1'b0, 0, 6'b011111, 6'b000001);
    step("after_reset", 1'b1, 0, 6'b011111, 6'b000001);
    for (int i = 0; i < 400; i++)
      step("random", ($urandom_range(0, 15) != 0), $urandom_range(0, 7),
           $urandom_range(0, M-1), $urandom_range(0, M-1));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
